fpu_divsqrt_ctrl: RTL and testbench
===================================

# fpu_divsqrt_ctrl

Sequencing controller for the shared iterative FP32 divide/square-root core. It accepts one request at a time over a valid/ready handshake and classifies the operands with two decoder instances. IEEE-754 special cases are resolved locally without touching the core. All other requests start the core, wait for completion under a watchdog, and return the result and exception flags to the FPU writeback stage over a second valid/ready handshake.

## Interface
Parameters:
- WAIT_MAX, 64: watchdog limit, in cycles spent in WAIT.
- CNT_W, 7: watchdog counter width. Must satisfy 2^CNT_W > WAIT_MAX.
- CANON_NAN, 32'h7FC00000: canonical quiet NaN.

Ports:
- clk_i, in, 1: clock; all logic is on the rising edge.
- reset_i, in, 1: asynchronous, active-low reset.
- req_valid_i, in, 1: request valid.
- req_ready_o, out, 1: request ready.
- req_op_i, in, 1: operation; 0 = DIV, 1 = SQRT.
- req_a_i, in, 32: operand a (dividend or radicand).
- req_b_i, in, 32: operand b (divisor); ignored for SQRT.
- req_rm_i, in, 3: rounding mode.
- flush_i, in, 1: pipeline kill.
- resp_valid_o, out, 1: response valid.
- resp_ready_i, in, 1: response ready.
- resp_result_o, out, 32: FP32 result.
- resp_fflags_o, out, 5: exception flags {NV,DZ,OF,UF,NX}.
- busy_o, out, 1: high whenever the state is not IDLE.
- err_o, out, 1: sticky watchdog error; cleared only by reset.
- core_start_o, out, 1: one-cycle start pulse to the core.
- core_abort_o, out, 1: one-cycle abort pulse to the core.
- core_op_o, out, 1: registered operation to the core.
- core_a_o, out, 32: registered operand a to the core.
- core_b_o, out, 32: registered operand b to the core.
- core_rm_o, out, 3: registered rounding mode to the core.
- core_done_i, in, 1: core completion, one-cycle pulse.
- core_result_i, in, 32: core result; valid with core_done_i.
- core_fflags_i, in, 5: core flags; valid with core_done_i.

## Operation
States and transitions:
- IDLE: req_ready_o = !flush_i. Request accepted when req_valid_i & req_ready_o; operands, op and rm are registered and the state goes to DECODE.
- DECODE: both operands are classified (zero, subnormal, inf, NaN, signaling).
  - Special case: result and flags are registered and the state goes to RESP.
  - Otherwise the state goes to START.
- START: core_start_o = 1 for this cycle only; the watchdog counter is cleared; the state goes to WAIT.
- WAIT: the counter increments every cycle.
  - core_done_i: core_result_i and core_fflags_i are registered and the state goes to RESP.
  - Counter reaches WAIT_MAX: core_abort_o is pulsed, the result is CANON_NAN, flags are 5'b10000, err_o is set, and the state goes to RESP.
- RESP: resp_valid_o = 1. Result and flags are held stable until resp_ready_i; then the state goes to IDLE.

Special cases for DIV (s = sign(a) ^ sign(b)):
- Either operand NaN: CANON_NAN; NV set if either operand is signaling.
- 0/0 or inf/inf: CANON_NAN, NV.
- finite nonzero / 0: inf with sign s, DZ.
- inf / finite: inf with sign s, no flags.
- 0 / finite nonzero, or finite / inf: zero with sign s, no flags.

Special cases for SQRT:
- NaN: CANON_NAN; NV if signaling.
- Sign set and operand nonzero (this includes -inf): CANON_NAN, NV.
- ±0: ±0, no flags.
- +inf: +inf, no flags.

Subnormal operands are not special cases; they go to the core.

flush_i has priority over every other event, in every state:
- The next state is IDLE and any pending response is discarded; resp_valid_o is 0 from the next cycle.
- If the state is WAIT, core_abort_o pulses in that cycle. A core_done_i arriving in the same cycle is ignored.

## Timing
- Reset values: state IDLE, req_ready_o 1, resp_valid_o 0, resp_result_o 0, resp_fflags_o 0, busy_o 0, err_o 0, core_start_o 0, core_abort_o 0, all core_* outputs 0.
- Reset asserted mid-operation: everything returns immediately to the reset values; no abort pulse is issued.
- Special-case latency: the request is accepted in cycle T and resp_valid_o rises at T+2.
- Core path: core_start_o is high in cycle T+2 and WAIT begins at T+3. core_done_i in cycle N gives resp_valid_o at N+1.
- Throughput: one request in flight at a time. After a response handshake in cycle R, req_ready_o is high at R+1.
- core_* operand outputs are driven from registers and held stable from START until the controller leaves WAIT.

## Structure
- Shared FPU package holds:
  - the OP_DIV and OP_SQRT encodings;
  - the state enum;
  - the fflags bit indices: NV = 4, DZ = 3, OF = 2, UF = 1, NX = 0;
  - the CANON_NAN constant.
- Sub-module: two fpu_decoder instances, one per registered operand. Special-case result selection is a combinational block inside this module.

## Test plan
- DIV 0x40400000 / 0x00000000: result 0x7F800000, fflags 5'b01000, resp_valid_o at T+2, core_start_o never asserted.
- SQRT 0xBF800000: result 0x7FC00000, fflags 5'b10000. SQRT 0x80000000: result 0x80000000, fflags 0.
- DIV 0x7F800001 / 0x3F800000: result 0x7FC00000, NV set. DIV 0x7FC00001 / 0x3F800000: result 0x7FC00000, flags 0.
- DIV 0x40C00000 / 0x40000000:
  - core_start_o is a single pulse at T+2;
  - core returns 0x40400000 after 10 cycles; resp_valid_o rises one cycle after core_done_i;
  - with resp_ready_i held low for 3 cycles, result stays 0x40400000 throughout.
- flush_i in WAIT at cycle 5:
  - core_abort_o is a one-cycle pulse, resp_valid_o is never asserted, and req_ready_o is 1 the next cycle;
  - a late core_done_i is ignored.
- Core never completes (WAIT_MAX = 64): core_abort_o fires after 64 cycles in WAIT, result 0x7FC00000, fflags 5'b10000, err_o stays high until reset_i is driven low.

Source files
------------

// File: rtl/fpu_divsqrt_ctrl_pkg.sv
// Shared FPU definitions for the divide/square-root sequencing controller:
// operation encodings, controller states, operand classes and flag positions.
package fpu_divsqrt_ctrl_pkg;

  localparam logic OP_DIV  = 1'b0;
  localparam logic OP_SQRT = 1'b1;

  // Bit positions inside the {NV,DZ,OF,UF,NX} flag vector.
  localparam int unsigned FF_NV = 4;
  localparam int unsigned FF_DZ = 3;
  localparam int unsigned FF_OF = 2;
  localparam int unsigned FF_UF = 1;
  localparam int unsigned FF_NX = 0;

  localparam logic [4:0]  FLAGS_NV = 5'b00001 << FF_NV;
  localparam logic [4:0]  FLAGS_DZ = 5'b00001 << FF_DZ;

  localparam logic [31:0] FP32_CANON_NAN = 32'h7FC00000;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StStart,
    StWait,
    StResp
  } state_e;

  typedef struct packed {
    logic sign;
    logic zero;
    logic subnormal;
    logic normal;
    logic inf;
    logic nan;
    logic snan;
  } fp_class_t;

endpackage

// File: rtl/fpu_decoder.sv
// FP32 operand classifier: sign, zero, subnormal, normal, infinity, NaN and
// signaling-NaN indications for one operand.
module fpu_decoder
  import fpu_divsqrt_ctrl_pkg::*;
(
  input  logic [31:0] operand_i,
  output fp_class_t   class_o
);

  logic [7:0]  w_exp;
  logic [22:0] w_man;
  logic        w_exp_zero;
  logic        w_exp_ones;
  logic        w_man_zero;

  assign w_exp      = operand_i[30:23];
  assign w_man      = operand_i[22:0];
  assign w_exp_zero = (w_exp == 8'h00);
  assign w_exp_ones = (w_exp == 8'hFF);
  assign w_man_zero = (w_man == 23'h0);

  assign class_o.sign      = operand_i[31];
  assign class_o.zero      = w_exp_zero & w_man_zero;
  assign class_o.subnormal = w_exp_zero & ~w_man_zero;
  assign class_o.normal    = ~w_exp_zero & ~w_exp_ones;
  assign class_o.inf       = w_exp_ones & w_man_zero;
  assign class_o.nan       = w_exp_ones & ~w_man_zero;
  // Quiet bit is the mantissa MSB; a NaN without it is signaling.
  assign class_o.snan      = w_exp_ones & ~w_man_zero & ~w_man[22];

endmodule

// File: rtl/fpu_divsqrt_ctrl.sv
// Sequencing controller for the shared iterative FP32 divide/sqrt core:
// resolves IEEE special cases locally, otherwise runs the core under a watchdog.
module fpu_divsqrt_ctrl
  import fpu_divsqrt_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX  = 64,
  parameter int unsigned CNT_W     = 7,
  parameter logic [31:0] CANON_NAN = FP32_CANON_NAN
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [2:0]  req_rm_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_result_o,
  output logic [4:0]  resp_fflags_o,
  output logic        busy_o,
  output logic        err_o,
  output logic        core_start_o,
  output logic        core_abort_o,
  output logic        core_op_o,
  output logic [31:0] core_a_o,
  output logic [31:0] core_b_o,
  output logic [2:0]  core_rm_o,
  input  logic        core_done_i,
  input  logic [31:0] core_result_i,
  input  logic [4:0]  core_fflags_i
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_op;
  logic [31:0]      r_a;
  logic [31:0]      r_b;
  logic [2:0]       r_rm;
  logic [31:0]      r_result;
  logic [4:0]       r_fflags;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  fp_class_t        w_ca;
  fp_class_t        w_cb;
  logic             w_div_sign;
  logic             w_sc_hit;
  logic [31:0]      w_sc_result;
  logic [4:0]       w_sc_fflags;
  logic             w_cnt_last;
  logic             w_accept;
  logic             w_load_sc;
  logic             w_load_core;
  logic             w_timeout;

  fpu_decoder u_dec_a (
    .operand_i (r_a),
    .class_o   (w_ca)
  );

  fpu_decoder u_dec_b (
    .operand_i (r_b),
    .class_o   (w_cb)
  );

  assign w_div_sign = w_ca.sign ^ w_cb.sign;
  assign w_cnt_last = (r_cnt == CNT_W'(WAIT_MAX - 1));

  // Special-case resolution; w_sc_hit low means the request needs the core.
  always_comb begin
    w_sc_hit    = 1'b1;
    w_sc_result = CANON_NAN;
    w_sc_fflags = '0;
    if (r_op == OP_SQRT) begin
      if (w_ca.nan) begin
        w_sc_fflags[FF_NV] = w_ca.snan;
      end else if (w_ca.sign && (w_ca.normal || w_ca.subnormal || w_ca.inf)) begin
        w_sc_fflags = FLAGS_NV;
      end else if (w_ca.zero) begin
        w_sc_result = r_a;
      end else if (w_ca.inf) begin
        w_sc_result = 32'h7F800000;
      end else begin
        w_sc_hit = 1'b0;
      end
    end else begin
      if (w_ca.nan || w_cb.nan) begin
        w_sc_fflags[FF_NV] = w_ca.snan | w_cb.snan;
      end else if ((w_ca.zero && w_cb.zero) || (w_ca.inf && w_cb.inf)) begin
        w_sc_fflags = FLAGS_NV;
      end else if (w_ca.inf) begin
        // inf / finite, including inf / 0, is an exact infinity.
        w_sc_result = {w_div_sign, 8'hFF, 23'h0};
      end else if (w_cb.zero) begin
        w_sc_result = {w_div_sign, 8'hFF, 23'h0};
        w_sc_fflags = FLAGS_DZ;
      end else if ((w_ca.zero && (w_cb.normal || w_cb.subnormal)) || w_cb.inf) begin
        w_sc_result = {w_div_sign, 31'h0};
      end else begin
        w_sc_hit = 1'b0;
      end
    end
  end

  // Next state and strobes; flush_i overrides everything in every state.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_load_sc    = 1'b0;
    w_load_core  = 1'b0;
    w_timeout    = 1'b0;
    core_start_o = 1'b0;
    core_abort_o = 1'b0;
    case (r_state)
      StIdle: begin
        if (!flush_i && req_valid_i) begin
          w_accept     = 1'b1;
          w_state_next = StDecode;
        end
      end
      StDecode: begin
        if (flush_i) begin
          w_state_next = StIdle;
        end else if (w_sc_hit) begin
          w_load_sc    = 1'b1;
          w_state_next = StResp;
        end else begin
          w_state_next = StStart;
        end
      end
      StStart: begin
        if (flush_i) begin
          w_state_next = StIdle;
        end else begin
          core_start_o = 1'b1;
          w_state_next = StWait;
        end
      end
      StWait: begin
        if (flush_i) begin
          core_abort_o = 1'b1;
          w_state_next = StIdle;
        end else if (core_done_i) begin
          w_load_core  = 1'b1;
          w_state_next = StResp;
        end else if (w_cnt_last) begin
          w_timeout    = 1'b1;
          core_abort_o = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        if (flush_i || resp_ready_i) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_state  <= StIdle;
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_rm     <= '0;
      r_result <= '0;
      r_fflags <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op <= req_op_i;
        r_a  <= req_a_i;
        r_b  <= req_b_i;
        r_rm <= req_rm_i;
      end
      if (r_state == StStart) begin
        r_cnt <= '0;
      end else if (r_state == StWait) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_load_sc) begin
        r_result <= w_sc_result;
        r_fflags <= w_sc_fflags;
      end else if (w_load_core) begin
        r_result <= core_result_i;
        r_fflags <= core_fflags_i;
      end else if (w_timeout) begin
        r_result <= CANON_NAN;
        r_fflags <= FLAGS_NV;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_ready_o   = (r_state == StIdle) && !flush_i;
  assign resp_valid_o  = (r_state == StResp);
  assign resp_result_o = r_result;
  assign resp_fflags_o = r_fflags;
  assign busy_o        = (r_state != StIdle);
  assign err_o         = r_err;
  assign core_op_o     = r_op;
  assign core_a_o      = r_a;
  assign core_b_o      = r_b;
  assign core_rm_o     = r_rm;

endmodule

// File: tb/tb_fpu_divsqrt_ctrl.sv
// Self-checking bench for fpu_divsqrt_ctrl: table of special-case vectors plus
// directed sequences for the core path, flush and watchdog timeout.
module tb_fpu_divsqrt_ctrl;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [2:0]  req_rm_i;
  logic        flush_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [31:0] resp_result_o;
  logic [4:0]  resp_fflags_o;
  logic        busy_o;
  logic        err_o;
  logic        core_start_o;
  logic        core_abort_o;
  logic        core_op_o;
  logic [31:0] core_a_o;
  logic [31:0] core_b_o;
  logic [2:0]  core_rm_o;
  logic        core_done_i;
  logic [31:0] core_result_i;
  logic [4:0]  core_fflags_i;

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  int abort_cnt = 0;
  int resp_cnt  = 0;
  int s0;
  int a0;
  int r0;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic [4:0]  exp_ff;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

  fpu_divsqrt_ctrl #(
    .WAIT_MAX  (64),
    .CNT_W     (7),
    .CANON_NAN (32'h7FC00000)
  ) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_a_i       (req_a_i),
    .req_b_i       (req_b_i),
    .req_rm_i      (req_rm_i),
    .flush_i       (flush_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_result_o (resp_result_o),
    .resp_fflags_o (resp_fflags_o),
    .busy_o        (busy_o),
    .err_o         (err_o),
    .core_start_o  (core_start_o),
    .core_abort_o  (core_abort_o),
    .core_op_o     (core_op_o),
    .core_a_o      (core_a_o),
    .core_b_o      (core_b_o),
    .core_rm_o     (core_rm_o),
    .core_done_i   (core_done_i),
    .core_result_i (core_result_i),
    .core_fflags_i (core_fflags_i)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (core_start_o) start_cnt <= start_cnt + 1;
    if (core_abort_o) abort_cnt <= abort_cnt + 1;
    if (resp_valid_o) resp_cnt  <= resp_cnt + 1;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Presents a request for one cycle (T); returns 1ns into cycle T+1.
  task automatic accept(input logic op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm);
    step();
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_rm_i    = rm;
    @(negedge clk_i);
    check("accept_ready", 32'(req_ready_o), 32'd1);
    step();
    req_valid_i = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h40400000, 32'h00000000, 32'h7F800000, 5'b01000};
    vecs[1]  = '{1'b1, 32'hBF800000, 32'h00000000, 32'h7FC00000, 5'b10000};
    vecs[2]  = '{1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 5'b00000};
    vecs[3]  = '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 5'b10000};
    vecs[4]  = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b00000};
    vecs[5]  = '{1'b0, 32'h00000000, 32'h00000000, 32'h7FC00000, 5'b10000};
    vecs[6]  = '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 5'b00000};
    vecs[7]  = '{1'b0, 32'h3F800000, 32'hFF800000, 32'h80000000, 5'b00000};
    vecs[8]  = '{1'b0, 32'h80000000, 32'h40000000, 32'h80000000, 5'b00000};
    vecs[9]  = '{1'b1, 32'h7F800000, 32'h00000000, 32'h7F800000, 5'b00000};
    vecs[10] = '{1'b1, 32'hFF800000, 32'h00000000, 32'h7FC00000, 5'b10000};
    vecs[11] = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 5'b10000};
    vecs[12] = '{1'b0, 32'h7F800000, 32'h80000000, 32'hFF800000, 5'b00000};
    vecs[13] = '{1'b1, 32'h7F800001, 32'h00000000, 32'h7FC00000, 5'b10000};
    vecs[14] = '{1'b0, 32'h3F800000, 32'h3FC00001, 32'h7FC00000, 5'b00000};
    // Entry 14 is replaced below: b is a signaling NaN with sign bit set.
    vecs[14] = '{1'b0, 32'h3F800000, 32'hFF800005, 32'h7FC00000, 5'b10000};

    reset_i       = 1'b0;
    req_valid_i   = 1'b0;
    req_op_i      = 1'b0;
    req_a_i       = '0;
    req_b_i       = '0;
    req_rm_i      = '0;
    flush_i       = 1'b0;
    resp_ready_i  = 1'b0;
    core_done_i   = 1'b0;
    core_result_i = '0;
    core_fflags_i = '0;
    #2;
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    check("rst_result", resp_result_o, 32'd0);
    check("rst_fflags", 32'(resp_fflags_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_start", 32'(core_start_o), 32'd0);
    check("rst_abort", 32'(core_abort_o), 32'd0);
    check("rst_core_a", core_a_o, 32'd0);
    check("rst_core_b", core_b_o, 32'd0);
    check("rst_core_op_rm", {28'd0, core_op_o, core_rm_o}, 32'd0);
    step();
    step();
    reset_i = 1'b1;
    @(negedge clk_i);
    check("idle_ready", 32'(req_ready_o), 32'd1);

    // Special cases resolve in two cycles without starting the core.
    for (int i = 0; i < NVEC; i++) begin
      s0 = start_cnt;
      accept(vecs[i].op, vecs[i].a, vecs[i].b, 3'b000);
      @(negedge clk_i);
      check($sformatf("sc%0d_t1_valid", i), 32'(resp_valid_o), 32'd0);
      step();
      @(negedge clk_i);
      check($sformatf("sc%0d_t2_valid", i), 32'(resp_valid_o), 32'd1);
      check($sformatf("sc%0d_result", i), resp_result_o, vecs[i].exp_res);
      check($sformatf("sc%0d_fflags", i), 32'(resp_fflags_o), 32'(vecs[i].exp_ff));
      resp_ready_i = 1'b1;
      step();
      resp_ready_i = 1'b0;
      @(negedge clk_i);
      check($sformatf("sc%0d_ready_after", i), 32'(req_ready_o), 32'd1);
      check($sformatf("sc%0d_valid_after", i), 32'(resp_valid_o), 32'd0);
      check($sformatf("sc%0d_no_start", i), 32'(start_cnt - s0), 32'd0);
    end

    // Core path: 6.0 / 2.0, core answers 10 cycles after start.
    s0 = start_cnt;
    accept(1'b0, 32'h40C00000, 32'h40000000, 3'b001);
    @(negedge clk_i);
    check("core_t1_start", 32'(core_start_o), 32'd0);
    step();
    @(negedge clk_i);
    check("core_t2_start", 32'(core_start_o), 32'd1);
    check("core_a", core_a_o, 32'h40C00000);
    check("core_b", core_b_o, 32'h40000000);
    check("core_op_rm", {28'd0, core_op_o, core_rm_o}, 32'h1);
    step();
    @(negedge clk_i);
    check("core_t3_start", 32'(core_start_o), 32'd0);
    check("core_t3_busy", 32'(busy_o), 32'd1);
    repeat (9) step();
    core_done_i   = 1'b1;
    core_result_i = 32'h40400000;
    core_fflags_i = 5'b00000;
    @(negedge clk_i);
    check("core_done_valid", 32'(resp_valid_o), 32'd0);
    check("core_wait_a_stable", core_a_o, 32'h40C00000);
    step();
    core_done_i   = 1'b0;
    core_result_i = 32'hDEADBEEF;
    core_fflags_i = 5'b11111;
    @(negedge clk_i);
    check("core_resp_valid", 32'(resp_valid_o), 32'd1);
    check("core_resp_result", resp_result_o, 32'h40400000);
    check("core_resp_fflags", 32'(resp_fflags_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      @(negedge clk_i);
      check($sformatf("core_hold%0d_valid", k), 32'(resp_valid_o), 32'd1);
      check($sformatf("core_hold%0d_result", k), resp_result_o, 32'h40400000);
    end
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    @(negedge clk_i);
    check("core_ready_after", 32'(req_ready_o), 32'd1);
    check("core_one_start", 32'(start_cnt - s0), 32'd1);

    // Flush in IDLE blocks acceptance.
    step();
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    #1;
    check("flush_idle_ready", 32'(req_ready_o), 32'd0);
    step();
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    @(negedge clk_i);
    check("flush_idle_busy", 32'(busy_o), 32'd0);

    // Flush during WAIT aborts the core and drops the request.
    a0 = abort_cnt;
    r0 = resp_cnt;
    accept(1'b0, 32'h3F800000, 32'h40000000, 3'b000);
    repeat (4) step();
    flush_i = 1'b1;
    @(negedge clk_i);
    check("flush_wait_abort", 32'(core_abort_o), 32'd1);
    step();
    flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_ready_next", 32'(req_ready_o), 32'd1);
    check("flush_abort_once", 32'(core_abort_o), 32'd0);
    step();
    core_done_i   = 1'b1;
    core_result_i = 32'h12345678;
    step();
    core_done_i = 1'b0;
    @(negedge clk_i);
    check("flush_late_done_busy", 32'(busy_o), 32'd0);
    check("flush_abort_count", 32'(abort_cnt - a0), 32'd1);
    check("flush_no_resp", 32'(resp_cnt - r0), 32'd0);

    // Core never completes: abort in the 64th WAIT cycle.
    a0 = abort_cnt;
    accept(1'b0, 32'h3F800000, 32'h40400000, 3'b000);
    step();
    step();
    repeat (62) step();
    @(negedge clk_i);
    check("wd_no_abort_early", 32'(core_abort_o), 32'd0);
    step();
    @(negedge clk_i);
    check("wd_abort", 32'(core_abort_o), 32'd1);
    check("wd_err_before", 32'(err_o), 32'd0);
    step();
    @(negedge clk_i);
    check("wd_resp_valid", 32'(resp_valid_o), 32'd1);
    check("wd_result", resp_result_o, 32'h7FC00000);
    check("wd_fflags", 32'(resp_fflags_o), 32'h10);
    check("wd_err", 32'(err_o), 32'd1);
    check("wd_abort_count", 32'(abort_cnt - a0), 32'd1);
    resp_ready_i = 1'b1;
    step();
    resp_ready_i = 1'b0;
    step();
    @(negedge clk_i);
    check("wd_err_sticky", 32'(err_o), 32'd1);

    // Reset in mid-operation (DECODE) clears everything at once.
    accept(1'b1, 32'h40800000, 32'h00000000, 3'b010);
    #1;
    reset_i = 1'b0;
    #1;
    check("rst_mid_err", 32'(err_o), 32'd0);
    check("rst_mid_busy", 32'(busy_o), 32'd0);
    check("rst_mid_core_a", core_a_o, 32'd0);
    check("rst_mid_ready", 32'(req_ready_o), 32'd1);
    check("rst_mid_abort", 32'(core_abort_o), 32'd0);
    step();
    reset_i = 1'b1;
    @(negedge clk_i);
    check("rst_mid_after_err", 32'(err_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
